// File: rtl/dmem_bus_ctrl_pkg.sv
// Shared definitions for the data-RAM bus controller: FSM encodings,
// byte-enable shorthands and the default RAM window base.
package dmem_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4
  } state_t;

  localparam logic [3:0]  BE_NONE       = 4'b0000;
  localparam logic [3:0]  BE_FULL       = 4'b1111;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0000;

endpackage

// File: rtl/dmem_bus_ctrl_if.sv
// CPU request/response handshake plus the RAM control outputs.
// The tristate data bus is carried as a separate inout port.
interface dmem_bus_ctrl_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic [3:0]            req_be;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rw;
  logic                  mem_cs;

  // requester side
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_rw, mem_cs
  );

  // controller side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_rw, mem_cs
  );
endinterface

// File: rtl/dmem_bus_ctrl_byte_lane_merge.sv
// Per-byte select between an existing word and new store data.
module byte_lane_merge (
  input  logic [31:0] old_w,
  input  logic [31:0] new_w,
  input  logic [3:0]  be,
  output logic [31:0] merged
);
  // lane i takes new data when its enable is set, otherwise keeps the old byte
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
  end
endmodule

// File: rtl/dmem_bus_ctrl.sv
// Upstream controller for the 4K x 32 tristate data RAM. Turns byte-
// addressed CPU requests into RAM cycles; partial stores use read-modify-
// write since the RAM has no byte enables. All mem_* outputs are registered
// because the RAM samples on both clock edges.
module dmem_bus_ctrl
  import dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR
) (
  input  logic                  CLK,
  input  logic                  Rst,
  dmem_bus_ctrl_if.slave        bus,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  state_t      state;
  logic        drv_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] merged;
  logic        in_win;
  logic        accept;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^bus.req_addr[1:0];

  // window check on the bits above the word address
  assign in_win = bus.req_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
  assign bus.req_ready = (state == IDLE) & ~Rst;
  assign accept = bus.req_valid & bus.req_ready;

  // bus is driven only while writing; released otherwise (incl. reset)
  assign mem_data = drv_q ? wdata_q : {DATA_WIDTH{1'bz}};

  byte_lane_merge u_merge (
    .old_w  (mem_data),
    .new_w  (wdata_q),
    .be     (be_q),
    .merged (merged)
  );

  // request FSM with registered RAM controls and response
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      state         <= IDLE;
      drv_q         <= 1'b0;
      wdata_q       <= '0;
      be_q          <= BE_NONE;
      bus.mem_addr  <= '0;
      bus.mem_rw    <= 1'b1;
      bus.mem_cs    <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          wdata_q <= bus.req_wdata;
          be_q    <= bus.req_be;
          if (!in_win) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
          end else if (bus.req_we && bus.req_be == BE_NONE) begin
            bus.rsp_valid <= 1'b1;
          end else begin
            bus.mem_addr <= bus.req_addr[ADDR_WIDTH+1:2];
            bus.mem_cs   <= 1'b1;
            if (!bus.req_we) begin
              state <= RD;
            end else if (bus.req_be == BE_FULL) begin
              state      <= WR;
              bus.mem_rw <= 1'b0;
              drv_q      <= 1'b1;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        RD: begin
          bus.rsp_rdata <= mem_data;
          bus.rsp_valid <= 1'b1;
          bus.mem_cs    <= 1'b0;
          state         <= IDLE;
        end
        RMW_RD: begin
          wdata_q    <= merged;
          bus.mem_rw <= 1'b0;
          drv_q      <= 1'b1;
          state      <= RMW_WR;
        end
        WR, RMW_WR: begin
          bus.mem_cs    <= 1'b0;
          bus.mem_rw    <= 1'b1;
          drv_q         <= 1'b0;
          bus.rsp_valid <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed bench for dmem_bus_ctrl with a simple behavioural 4K x 32 RAM.
module tb_dmem_bus_ctrl;

  logic        CLK = 1'b0;
  logic        Rst = 1'b1;
  wire  [31:0] mem_data;

  dmem_bus_ctrl_if #(.ADDR_WIDTH(12)) bus ();

  dmem_bus_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .BASE_ADDR(32'h1001_0000)) dut (
    .CLK      (CLK),
    .Rst      (Rst),
    .bus      (bus),
    .mem_data (mem_data)
  );

  always #5 CLK = ~CLK;

  // RAM model: combinational read while selected, write on posedge
  logic [31:0] ram [0:4095];
  logic        ram_oe;
  assign ram_oe   = bus.mem_cs & bus.mem_rw;
  assign mem_data = ram_oe ? ram[bus.mem_addr] : 32'hzzzz_zzzz;
  always @(posedge CLK) if (bus.mem_cs && !bus.mem_rw) ram[bus.mem_addr] <= mem_data;

  // RAM activity monitor
  int          rd_cnt, wr_cnt;
  logic [11:0] last_addr;
  always @(negedge CLK) begin
    if (bus.mem_cs) begin
      if (bus.mem_rw) rd_cnt <= rd_cnt + 1;
      else            wr_cnt <= wr_cnt + 1;
      last_addr <= bus.mem_addr;
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // one request from a negedge; returns edges from accept to rsp_valid
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, output int lat, output logic [31:0] rd,
                      output logic err);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_be    = be;
    @(posedge CLK);
    #1 bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(posedge CLK);
      #1 lat++;
    end
    rd  = bus.rsp_rdata;
    err = bus.rsp_err;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        err;
  int          pulses;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    rd_cnt = 0; wr_cnt = 0; last_addr = '0;

    // reset state
    repeat (2) @(negedge CLK);
    check("rst_ready",  {31'd0, bus.req_ready}, 32'd0);
    check("rst_cs",     {31'd0, bus.mem_cs},    32'd0);
    check("rst_rw",     {31'd0, bus.mem_rw},    32'd1);
    check("rst_addr",   {20'd0, bus.mem_addr},  32'd0);
    check("rst_vld",    {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_err",    {31'd0, bus.rsp_err},   32'd0);
    check("rst_rdata",  bus.rsp_rdata,          32'd0);
    Rst = 1'b0;
    #1 check("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);
    @(negedge CLK);

    // full store then load
    rd_cnt = 0; wr_cnt = 0;
    xfer(1'b1, 32'h1001_0010, 32'hDEAD_BEEF, 4'hF, lat, rd, err);
    check("st_full_lat", lat, 2);
    check("st_full_err", {31'd0, err}, 0);
    check("st_full_wr",  wr_cnt, 1);
    check("st_full_rd",  rd_cnt, 0);
    check("st_full_adr", {20'd0, last_addr}, 32'h004);
    @(negedge CLK);
    xfer(1'b0, 32'h1001_0010, 32'h0, 4'h0, lat, rd, err);
    check("ld_lat",   lat, 2);
    check("ld_data",  rd, 32'hDEAD_BEEF);
    check("ld_err",   {31'd0, err}, 0);
    @(negedge CLK);

    // partial store with RMW
    xfer(1'b1, 32'h1001_0014, 32'h1122_3344, 4'hF, lat, rd, err);
    @(negedge CLK);
    rd_cnt = 0; wr_cnt = 0;
    xfer(1'b1, 32'h1001_0014, 32'h0000_AB00, 4'b0010, lat, rd, err);
    check("rmw_lat", lat, 3);
    check("rmw_rd",  rd_cnt, 1);
    check("rmw_wr",  wr_cnt, 1);
    check("rmw_adr", {20'd0, last_addr}, 32'h005);
    check("rmw_rdata_held", rd, 32'hDEAD_BEEF);
    @(negedge CLK);
    xfer(1'b0, 32'h1001_0014, 32'h0, 4'h0, lat, rd, err);
    check("rmw_ld", rd, 32'h1122_AB44);
    @(negedge CLK);

    // out of range load
    rd_cnt = 0; wr_cnt = 0;
    xfer(1'b0, 32'h0040_0000, 32'h0, 4'h0, lat, rd, err);
    check("oor_lat",   lat, 1);
    check("oor_err",   {31'd0, err}, 1);
    check("oor_ready", {31'd0, bus.req_ready}, 1);
    @(negedge CLK);
    check("oor_cs", rd_cnt + wr_cnt, 0);

    // empty byte enable store
    xfer(1'b1, 32'h1001_0000, 32'hFFFF_FFFF, 4'h0, lat, rd, err);
    check("be0_lat", lat, 1);
    check("be0_err", {31'd0, err}, 0);
    @(negedge CLK);
    check("be0_cs", rd_cnt + wr_cnt, 0);

    // top word and first address past the window
    xfer(1'b1, 32'h1001_3FFC, 32'hCAFE_F00D, 4'hF, lat, rd, err);
    check("top_adr", {20'd0, last_addr}, 32'hFFF);
    check("top_err", {31'd0, err}, 0);
    @(negedge CLK);
    xfer(1'b0, 32'h1001_3FFC, 32'h0, 4'h0, lat, rd, err);
    check("top_ld", rd, 32'hCAFE_F00D);
    @(negedge CLK);
    xfer(1'b0, 32'h1001_4000, 32'h0, 4'h0, lat, rd, err);
    check("past_err", {31'd0, err}, 1);
    check("past_lat", lat, 1);
    @(negedge CLK);

    // back-to-back loads with req_valid held
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h1001_0010;
    @(posedge CLK);
    #1 bus.req_addr = 32'h1001_0014;
    check("b2b_v0", {31'd0, bus.rsp_valid}, 0);
    @(posedge CLK);
    #1 check("b2b_v1",  {31'd0, bus.rsp_valid}, 1);
    check("b2b_d1",  bus.rsp_rdata, 32'hDEAD_BEEF);
    check("b2b_rdy", {31'd0, bus.req_ready}, 1);
    @(posedge CLK);
    #1 bus.req_valid = 1'b0;
    check("b2b_v2", {31'd0, bus.rsp_valid}, 0);
    @(posedge CLK);
    #1 check("b2b_v3", {31'd0, bus.rsp_valid}, 1);
    check("b2b_d3", bus.rsp_rdata, 32'h1122_AB44);
    @(negedge CLK);

    // reset during RMW read phase
    xfer(1'b1, 32'h1001_0018, 32'h5566_7788, 4'hF, lat, rd, err);
    @(negedge CLK);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h1001_0018;
    bus.req_wdata = 32'h0000_00AA;
    bus.req_be    = 4'b0001;
    @(posedge CLK);
    #1 bus.req_valid = 1'b0;
    check("rmwrst_cs_pre", {31'd0, bus.mem_cs}, 1);
    #1 Rst = 1'b1;
    #1 check("rmwrst_cs", {31'd0, bus.mem_cs},    0);
    check("rmwrst_rw",    {31'd0, bus.mem_rw},    1);
    check("rmwrst_rdy",   {31'd0, bus.req_ready}, 0);
    @(negedge CLK);
    @(negedge CLK);
    Rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #1 if (bus.rsp_valid) pulses++;
    end
    check("rmwrst_no_rsp", pulses, 0);
    check("rmwrst_ready", {31'd0, bus.req_ready}, 1);
    @(negedge CLK);
    xfer(1'b0, 32'h1001_0018, 32'h0, 4'h0, lat, rd, err);
    check("rmwrst_word", rd, 32'h5566_7788);
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
